// File: rtl/clk_buffer_multi.sv
// ---------------------------------------------------------------------------
// clk_buffer_multi
//
// Multi-channel input synchroniser for asynchronous external lines such as
// triggers, PMT gates and TTL inputs. Each channel passes through a
// STAGES-deep flop chain and then a registered output stage. That output
// stage also produces one-cycle rise and fall strobes. The result feeds the
// pulse-sequencer and counter logic in the clk domain.
//
// Optional feature: define CLK_BUFFER_MULTI_FILTER_EN to add a per-channel
// glitch filter. When enabled, a new level must stay stable for
// filter_len+1 consecutive cycles before q accepts it. The default build
// has no filter. In that build filter_len is ignored and no counter flops
// exist.
//
// Parameters:
//   WIDTH        number of independent channels
//   STAGES       synchroniser flops ahead of the output register (1..4)
//   FILTER_BITS  width of the per-channel glitch-filter counter
//   RESET_VAL    reset value of the sync chain and q
//
// Ports:
//   clk         in   1            system clock, all logic on posedge
//   rst_n       in   1            asynchronous, active-low reset
//   in          in   WIDTH        asynchronous inputs
//   filter_len  in   FILTER_BITS  glitch-filter hold length, quasi-static
//   q           out  WIDTH        synchronised (and filtered) level
//   rise        out  WIDTH        one-cycle strobe, q[i] went 0->1
//   fall        out  WIDTH        one-cycle strobe, q[i] went 1->0
//   change      out  1            high in any cycle where rise or fall is high
// ---------------------------------------------------------------------------
module clk_buffer_multi #(
    parameter int               WIDTH       = 8,
    parameter int               STAGES      = 2,
    parameter int               FILTER_BITS = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in,
    input  logic [FILTER_BITS-1:0] filter_len,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       rise,
    output logic [WIDTH-1:0]       fall,
    output logic                   change
);

    logic [WIDTH-1:0] sync [STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // The synchroniser chain and q share one reset value.
    // As a result, no spurious edge is seen when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync[k] <= RESET_VAL;
            end
        end else begin
            sync[0] <= in;
            for (int k = 1; k < STAGES; k++) begin
                sync[k] <= sync[k-1];
            end
        end
    end

    assign s = sync[STAGES-1];

`ifdef CLK_BUFFER_MULTI_FILTER_EN
    logic [FILTER_BITS-1:0] cnt [WIDTH];

    // A differing level is accepted only once it has already been seen
    // filter_len times in a row.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = (s[i] != q[i]) && (cnt[i] == filter_len);
        end
    end

    // The counter clears whenever s agrees with q, and also on acceptance.
    // It therefore never passes filter_len and cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == filter_len) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    logic unused_filter_len;
    assign unused_filter_len = ^filter_len;

    // Without the filter, every difference between s and q is taken at once.
    always_comb begin
        accept = s ^ q;
    end
`endif

    // Build the next q and the edge strobes from the channels accepted this cycle.
    always_comb begin
        q_next    = (q & ~accept) | (s & accept);
        rise_next = accept & s & ~q;
        fall_next = accept & ~s & q;
    end

    // The strobes are registered together with q. Each strobe is therefore
    // high exactly in the first cycle that q shows its new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= RESET_VAL;
            rise   <= '0;
            fall   <= '0;
            change <= 1'b0;
        end else begin
            q      <= q_next;
            rise   <= rise_next;
            fall   <= fall_next;
            change <= |(rise_next | fall_next);
        end
    end

endmodule

// File: tb/tb_clk_buffer_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_buffer_multi
//
// Directed testbench for clk_buffer_multi using the default parameters
// WIDTH=8, STAGES=2. The stimulus covers reset behaviour, single-channel
// latency, multi-channel edges and mid-run asynchronous reset. A random
// stretch is checked against input history delayed by three edges. When
// CLK_BUFFER_MULTI_FILTER_EN is defined, glitch-filter scenarios also run.
// ---------------------------------------------------------------------------
module tb_clk_buffer_multi;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [3:0] filter_len;
    logic [7:0] q;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       change;

    int vectors     = 0;
    int miscompares = 0;

    clk_buffer_multi #(
        .WIDTH      (8),
        .STAGES     (2),
        .FILTER_BITS(4),
        .RESET_VAL  (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (din),
        .filter_len(filter_len),
        .q         (q),
        .rise      (rise),
        .fall      (fall),
        .change    (change)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then sample 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] value);
        din = value;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] eq,
                             input logic [7:0] er, input logic [7:0] ef);
        check_output({tag, ".q"}, q, eq);
        check_output({tag, ".rise"}, rise, er);
        check_output({tag, ".fall"}, fall, ef);
        check_output({tag, ".change"}, {7'd0, change}, {7'd0, |(er | ef)});
    endtask

    logic [7:0] hist [4];
    logic [7:0] d;

    initial begin
        rst_n      = 1'b0;
        filter_len = 4'd0;
        apply_stimulus(8'h00);
        tick();
        tick();
        check_all("reset_state", 8'h00, 8'h00, 8'h00);

        // Release reset with inputs low: no strobes are expected for 10 cycles.
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("post_reset_idle", 8'h00, 8'h00, 8'h00);
        end

        // Latency: a step on in[3] reaches q on the third edge after it is driven.
        apply_stimulus(8'h08);
        tick();
        check_all("lat_edge0", 8'h00, 8'h00, 8'h00);
        tick();
        check_all("lat_edge1", 8'h00, 8'h00, 8'h00);
        tick();
        check_all("lat_edge2", 8'h08, 8'h08, 8'h00);
        tick();
        check_all("lat_edge3", 8'h08, 8'h00, 8'h00);

        // Return to zero; this produces a fall strobe on channel 3.
        apply_stimulus(8'h00);
        tick();
        tick();
        tick();
        check_all("fall_ch3", 8'h00, 8'h00, 8'h08);
        tick();
        check_all("fall_ch3_end", 8'h00, 8'h00, 8'h00);

        // Multi-channel: 00 -> A5, then A5 -> 5A.
        apply_stimulus(8'hA5);
        tick();
        tick();
        tick();
        check_all("multi_a5", 8'hA5, 8'hA5, 8'h00);
        apply_stimulus(8'h5A);
        tick();
        check_all("multi_hold", 8'hA5, 8'h00, 8'h00);
        tick();
        tick();
        check_all("multi_5a", 8'h5A, 8'h5A, 8'hA5);
        tick();
        check_all("multi_5a_end", 8'h5A, 8'h00, 8'h00);

        // Mid-run reset with all inputs high. Reset clears q immediately,
        // between clock edges.
        apply_stimulus(8'hFF);
        tick();
        tick();
        tick();
        check_all("all_high", 8'hFF, 8'hA5, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 8'h00, 8'h00, 8'h00);
        tick();
        check_all("reset_held", 8'h00, 8'h00, 8'h00);
        apply_stimulus(8'h00);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("release_idle", 8'h00, 8'h00, 8'h00);
        end

        // Random stretch: q follows the value driven two iterations earlier.
        for (int k = 0; k < 4; k++) hist[k] = 8'h00;
        for (int j = 0; j < 200; j++) begin
            d = 8'($urandom);
            if (j % 5 == 0) d = hist[0];
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = d;
            apply_stimulus(d);
            tick();
            check_all("random", hist[2], hist[2] & ~hist[3], ~hist[2] & hist[3]);
        end

`ifdef CLK_BUFFER_MULTI_FILTER_EN
        // Settle to zero before the filter scenarios.
        apply_stimulus(8'h00);
        for (int i = 0; i < 5; i++) tick();
        filter_len = 4'd3;

        // A 3-cycle pulse is rejected.
        apply_stimulus(8'h01);
        tick();
        tick();
        tick();
        apply_stimulus(8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_all("filt_short", 8'h00, 8'h00, 8'h00);
        end

        // A 4-cycle pulse is accepted on the 6th edge, and the fall follows
        // after 4 low cycles.
        apply_stimulus(8'h01);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) apply_stimulus(8'h00);
            check_all("filt_wait", 8'h00, 8'h00, 8'h00);
        end
        tick();
        check_all("filt_rise", 8'h01, 8'h01, 8'h00);
        for (int i = 7; i <= 9; i++) begin
            tick();
            check_all("filt_hold", 8'h01, 8'h00, 8'h00);
        end
        tick();
        check_all("filt_fall", 8'h00, 8'h00, 8'h01);

        // Reset mid-filter: a full hold is needed again after reset.
        for (int i = 0; i < 5; i++) tick();
        filter_len = 4'd5;
        apply_stimulus(8'h01);
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check_all("filt_reset", 8'h00, 8'h00, 8'h00);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check_all("filt_rehold", 8'h00, 8'h00, 8'h00);
        end
        tick();
        check_all("filt_reaccept", 8'h01, 8'h01, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
